// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding and the digit width handled per clock.
package serial_magnitude_comparator_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/serial_magnitude_comparator_two_bit.sv
// Two-bit unsigned compare cell. Purely combinational; exactly one of
// gt/eq/lt is high for any input pair.
module two_bit_comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  // Decode the relation of the two digits.
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial WIDTH-bit unsigned magnitude comparator. Walks the operands
// MSB-first, one 2-bit digit per clock, through a single two_bit_comparator
// and stops at the first unequal digit or after the last digit.
//
// Handshake: start is a request sampled only while idle (busy=0); an
// accepted start raises busy on the same edge. done is a one-cycle pulse
// marking greater/equal/lesser valid; busy stays high through that cycle
// and drops on the following edge, after which the next start is taken.
// There is no back-pressure and requests seen while busy are dropped.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             lesser
);

  localparam int NDIG = WIDTH / DIGIT_W;
  // Counter only needs to reach NDIG-1; keep at least one bit for NDIG=1.
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  // Current FSM state; kept as a named signal so checkers can bind to it.
  cmp_state_e       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    dig_cnt;

  logic dig_gt;
  logic dig_eq;
  logic dig_lt;

  two_bit_comparator u_digit (
    .a  (a_reg[WIDTH-1 -: DIGIT_W]),
    .b  (b_reg[WIDTH-1 -: DIGIT_W]),
    .gt (dig_gt),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  // Control FSM with registered busy/done and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      dig_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
      lesser  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            dig_cnt <= LAST_IDX;
            busy    <= 1'b1;
            greater <= 1'b0;
            equal   <= 1'b0;
            lesser  <= 1'b0;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (dig_gt) begin
            greater <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else if (dig_lt) begin
            lesser <= 1'b1;
            done   <= 1'b1;
            state  <= DONE;
          end else if (dig_eq && (dig_cnt == '0)) begin
            equal <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Digit tie: bring the next lower digit into the compare cell.
            a_reg   <= a_reg << DIGIT_W;
            b_reg   <= b_reg << DIGIT_W;
            dig_cnt <= dig_cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator at WIDTH=8. Expected
// values are worked out by hand from the operand digits.
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         greater;
  logic         equal;
  logic         lesser;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .greater (greater),
    .equal   (equal),
    .lesser  (lesser)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check busy, done and flags {greater,equal,lesser} together.
  task automatic check_all(input string tag, input logic b, input logic d, input logic [2:0] f);
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    check({tag, ".done"}, {7'd0, done}, {7'd0, d});
    check({tag, ".flags"}, {5'd0, greater, equal, lesser}, {5'd0, f});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    tick();
    check_all("idle_after_reset", 1'b0, 1'b0, 3'b000);

    // A5 vs A5: all four digits tie -> equal after 4 digits.
    a_in = 8'hA5; b_in = 8'hA5; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    check_all("eq.e0", 1'b1, 1'b0, 3'b000);
    tick(); check_all("eq.e1", 1'b1, 1'b0, 3'b000);
    tick(); check_all("eq.e2", 1'b1, 1'b0, 3'b000);
    tick(); check_all("eq.e3", 1'b1, 1'b0, 3'b000);
    tick(); check_all("eq.e4", 1'b1, 1'b1, 3'b010);
    tick(); check_all("eq.e5", 1'b0, 1'b0, 3'b010);
    tick(); check_all("eq.hold", 1'b0, 1'b0, 3'b010);

    // 80 vs 7F: top digit 10 > 01 -> greater after 1 digit.
    a_in = 8'h80; b_in = 8'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("gt.e0", 1'b1, 1'b0, 3'b000);
    tick(); check_all("gt.e1", 1'b1, 1'b1, 3'b100);
    tick(); check_all("gt.e2", 1'b0, 1'b0, 3'b100);

    // 12 vs 13: digits 00 01 00 10 vs 00 01 00 11 -> lesser on digit 4.
    a_in = 8'h12; b_in = 8'h13; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("lt.e0", 1'b1, 1'b0, 3'b000);
    tick(); check_all("lt.e1", 1'b1, 1'b0, 3'b000);
    tick(); check_all("lt.e2", 1'b1, 1'b0, 3'b000);
    tick(); check_all("lt.e3", 1'b1, 1'b0, 3'b000);
    tick(); check_all("lt.e4", 1'b1, 1'b1, 3'b001);
    tick(); check_all("lt.e5", 1'b0, 1'b0, 3'b001);

    // 40 vs 30, then swap operands and re-pulse start while busy.
    a_in = 8'h40; b_in = 8'h30; start = 1'b1;
    tick();
    a_in = 8'h00; b_in = 8'hFF;               // start stays high: ignored
    check_all("ign.e0", 1'b1, 1'b0, 3'b000);
    tick(); check_all("ign.e1", 1'b1, 1'b1, 3'b100);
    start = 1'b0;
    tick(); check_all("ign.e2", 1'b0, 1'b0, 3'b100);
    tick(); check_all("ign.no_queue", 1'b0, 1'b0, 3'b100);

    // 00 vs 01, reset after two compare cycles.
    a_in = 8'h00; b_in = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_all("abort.before", 1'b1, 1'b0, 3'b000);
    rst = 1'b1;
    #1;
    check_all("abort.async", 1'b0, 1'b0, 3'b000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all("abort.quiet", 1'b0, 1'b0, 3'b000);
    end

    // Rerun 00 vs 01 normally -> lesser on the last digit.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); check_all("rerun.e1", 1'b1, 1'b0, 3'b000);
    tick(); check_all("rerun.e2", 1'b1, 1'b0, 3'b000);
    tick(); check_all("rerun.e3", 1'b1, 1'b0, 3'b000);
    tick(); check_all("rerun.e4", 1'b1, 1'b1, 3'b001);
    tick(); check_all("rerun.e5", 1'b0, 1'b0, 3'b001);

    // Back-to-back with start held high.
    // FF vs FE: 11 11 11 11 vs 11 11 11 10 -> greater on digit 4.
    a_in = 8'hFF; b_in = 8'hFE; start = 1'b1;
    tick();                                   // E0 accepted
    a_in = 8'h01; b_in = 8'h02;
    check_all("b2b.a.e0", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.a.e1", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.a.e2", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.a.e3", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.a.e4", 1'b1, 1'b1, 3'b100);
    tick(); check_all("b2b.a.e5", 1'b0, 1'b0, 3'b100);
    // 01 vs 02: 00 00 00 01 vs 00 00 00 10 -> lesser on digit 4.
    tick(); check_all("b2b.b.e0", 1'b1, 1'b0, 3'b000);
    start = 1'b0;
    tick(); check_all("b2b.b.e1", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.b.e2", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.b.e3", 1'b1, 1'b0, 3'b000);
    tick(); check_all("b2b.b.e4", 1'b1, 1'b1, 3'b001);
    tick(); check_all("b2b.b.e5", 1'b0, 1'b0, 3'b001);
    tick(); check_all("b2b.idle", 1'b0, 1'b0, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Compares two WIDTH-bit unsigned operands serially, 2 bits per clock, MSB-first.
- Each cycle, one 2-bit digit pair goes into one two_bit_comparator instance; its greater/equal/lesser flags are accumulated into a wide result.
- Terminates on the first unequal digit pair, or after the last digit.
- Sits downstream of two_bit_comparator and lets the 2-bit compare cell serve wide operands (counters, address bounds) without a full-width comparator.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2.
- NDIG, WIDTH/2, number of 2-bit digits. Local, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- a_in  input  WIDTH  operand A. Captured on the accepted start edge.
- b_in  input  WIDTH  operand B. Captured on the accepted start edge.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  one-cycle pulse: result valid.
- greater  output  1  A > B.
- equal  output  1  A == B.
- lesser  output  1  A < B.

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE.
  - busy, done, greater, equal and lesser all go to 0.
  - Operand registers and digit counter go to 0.
  - Reset mid-compare aborts immediately. No done pulse; flags stay 000 until a new result.
- IDLE:
  - start=1 at an edge: latch a_in and b_in into a_reg and b_reg, load digit counter with NDIG-1, clear greater/equal/lesser to 000, go to COMPARE.
  - start=0: stay in IDLE; flags hold the last result.
- COMPARE, one digit per cycle:
  - The sub-module compares a_reg[WIDTH-1:WIDTH-2] against b_reg[WIDTH-1:WIDTH-2].
  - Digit greater: set greater=1, go to DONE.
  - Digit lesser: set lesser=1, go to DONE.
  - Digit equal and counter==0: set equal=1, go to DONE.
  - Otherwise: shift a_reg and b_reg left by 2, decrement the counter, stay in COMPARE.
- DONE:
  - done=1 for exactly this cycle, busy=1.
  - Go to IDLE on the next edge.
  - Flags hold until the next accepted start.
- Latency:
  - Start sampled at edge E0; k = number of digits examined (1..NDIG).
  - Flags update at edge Ek; done is high in the cycle after Ek.
  - Worst case NDIG+1 cycles from start to done.
- Throughput:
  - start is ignored in COMPARE and DONE; there is no queueing.
  - The next start is accepted in the first IDLE cycle after done.
- Flags:
  - Exactly one of greater/equal/lesser is 1 whenever a result is valid.
  - All three are 0 from an accepted start until the result arrives, and after reset.
- Operand changes after capture have no effect.
- No arithmetic beyond the counter, which is $clog2(NDIG) bits wide (minimum 1) and never wraps: exit happens at 0.

Decomposition:
- Shared package:
  - state encoding typedef: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2.
  - DIGIT_W=2 constant.
- One sub-module: two_bit_comparator, instantiated once on the top digits of a_reg/b_reg. Its outputs are combinational inputs to the FSM.
- Everything else lives in the top module.

Test Plan (WIDTH=8):
- Reset, then a_in=8'hA5, b_in=8'hA5, start pulse -> after 4 compare cycles: equal=1, greater=0, lesser=0, done high for 1 cycle, 5 cycles after the start edge.
- a_in=8'h80, b_in=8'h7F, start -> greater=1 after 1 digit; done 2 cycles after start; busy drops the cycle after done.
- a_in=8'h12, b_in=8'h13, start -> lesser=1 after 4 digits; flags read 000 during COMPARE.
- Start with 8'h40 vs 8'h30; change a_in/b_in and pulse start again while busy -> second start ignored; result greater=1 from the captured operands.
- Start 8'h00 vs 8'h01; assert rst after 2 cycles -> busy, done and flags go to 0 immediately; no done pulse after rst releases; a new start runs normally.
- Back-to-back: hold start=1 continuously, alternating operands (8'hFF vs 8'hFE, then 8'h01 vs 8'h02) -> one done per transaction; second start accepted in the first IDLE cycle after done; results greater then lesser.
